// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I core:
// FSM states, opcodes, ALU codes, immediate formats, mux selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU function decode from ALUOp and instruction fields.
// Subtract only for R-type with funct7b5 set; I-type never subtracts.
module aludec
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FN: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct7b5) alu_control = ALU_SUB;
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the multicycle RV32I datapath.
// immSrc decodes straight from op, independent of state.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] stateDbg
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    alu_op    = ALUOP_ADD;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  state_d = S_MEMADR;
          (op == OP_R):   state_d = S_EXECR;
          (op == OP_I):   state_d = S_EXECI;
          (op == OP_BEQ): state_d = S_BEQ;
          (op == OP_JAL): state_d = S_JAL;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FN;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FN;
        state_d = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_4;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    immSrc = IMM_I;
    unique case (1'b1)
      (op == OP_SW):  immSrc = IMM_S;
      (op == OP_BEQ): immSrc = IMM_B;
      (op == OP_JAL): immSrc = IMM_J;
      default:        immSrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign PCWrite  = pc_update | (branch & zero);
  assign stateDbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
  logic [2:0] ALUControl;
  logic [3:0] stateDbg;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .immSrc(immSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc),
    .ALUControl(ALUControl), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .stateDbg(stateDbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic       adr;
    logic [2:0] alu;
    logic       ir;
    logic       pcw;
    logic       rw;
    logic       mw;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       act;
  logic [1:0] imm_e;
  int         n_cmp = 0;
  int         n_bad = 0;

  assign act = {stateDbg, immSrc, ALUSrcA, ALUSrcB, ResultSrc,
                AdrSrc, ALUControl, IRWrite, PCWrite,
                RegWrite, MemWrite};

  // Expected Moore outputs per state; unlisted fields stay 0.
  function automatic obs_t model(input logic [3:0] s,
                                 input logic [1:0] im,
                                 input logic [2:0] al,
                                 input logic z);
    obs_t e;
    e     = '0;
    e.st  = s;
    e.imm = im;
    e.alu = al;
    case (s)
      4'd0:  begin e.b = 2'b10; e.res = 2'b10;
                   e.ir = 1'b1; e.pcw = 1'b1; end
      4'd1:  begin e.a = 2'b01; e.b = 2'b01; end
      4'd2:  begin e.a = 2'b10; e.b = 2'b01; end
      4'd3:  e.adr = 1'b1;
      4'd4:  begin e.res = 2'b01; e.rw = 1'b1; end
      4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
      4'd6:  e.a = 2'b10;
      4'd7:  begin e.a = 2'b10; e.b = 2'b01; end
      4'd8:  e.rw = 1'b1;
      4'd9:  begin e.a = 2'b10; e.pcw = z; end
      4'd10: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [2:0] al);
    exp_q.push_back(model(s, imm_e, al, zero));
  endtask

  // st/ac hold per-cycle state and ALUControl, cycle 0 in low bits.
  task automatic run(input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z,
                     input logic [1:0] im, input int n,
                     input logic [19:0] st, input logic [14:0] ac);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    zero     = z;
    imm_e    = im;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      push(st[4*i +: 4], ac[3*i +: 3]);
    end
    tick();
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL cycle st=%0d: got %05h expected %05h",
                 e.st, act, e);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    op       = 7'h7f;
    funct3   = 3'd0;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    imm_e    = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    // lw with zero high, which must not matter outside BEQ
    run(7'b0000011, 3'b010, 1'b0, 1'b1, 2'b00, 5,
        {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 15'd0);
    run(7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 4,
        {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 15'd0);
    run(7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3,
        {8'd0, 4'd9, 4'd1, 4'd0}, {9'd0, 3'b001, 6'd0});
    run(7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 3,
        {8'd0, 4'd9, 4'd1, 4'd0}, {9'd0, 3'b001, 6'd0});
    run(7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 4,
        {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, {6'd0, 3'b001, 6'd0});
    run(7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 4,
        {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, {6'd0, 3'b000, 6'd0});
    run(7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 4,
        {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, {6'd0, 3'b010, 6'd0});
    run(7'b0110011, 3'b010, 1'b0, 1'b0, 2'b00, 4,
        {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, {6'd0, 3'b101, 6'd0});
    run(7'b0110011, 3'b110, 1'b0, 1'b0, 2'b00, 4,
        {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, {6'd0, 3'b011, 6'd0});
    run(7'b0110011, 3'b100, 1'b0, 1'b0, 2'b00, 4,
        {4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, {6'd0, 3'b000, 6'd0});
    // addi with funct7b5 set still adds: op[5] is 0
    run(7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 4,
        {4'd0, 4'd8, 4'd7, 4'd1, 4'd0}, {6'd0, 3'b000, 6'd0});
    run(7'b0010011, 3'b111, 1'b0, 1'b0, 2'b00, 4,
        {4'd0, 4'd8, 4'd7, 4'd1, 4'd0}, {6'd0, 3'b010, 6'd0});
    run(7'b1101111, 3'b000, 1'b0, 1'b0, 2'b11, 4,
        {4'd0, 4'd8, 4'd10, 4'd1, 4'd0}, 15'd0);
    run(7'b1111111, 3'b000, 1'b0, 1'b0, 2'b00, 2,
        {12'd0, 4'd1, 4'd0}, 15'd0);
    // reset in MEMREAD aborts the lw before its MEMWB write
    op       = 7'b0000011;
    funct3   = 3'b010;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    imm_e    = 2'b00;
    push(4'd0, 3'd0);
    tick();
    push(4'd1, 3'd0);
    tick();
    push(4'd2, 3'd0);
    tick();
    push(4'd3, 3'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 4,
        {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 15'd0);
    run(7'b1111111, 3'b000, 1'b0, 1'b0, 2'b00, 2,
        {12'd0, 4'd1, 4'd0}, 15'd0);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control unit for the multicycle RV32I core. It sequences the shared ALU, the unified instruction/data memory, the register file and the immediate extender across several clock cycles per instruction, using a Moore state machine. It drives `immSrc` for the immediate extender, plus every mux select and write enable in the datapath. It sits beside the datapath and sees only the fetched instruction fields and the ALU `zero` flag.

## Interface
- Parameters: none.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; forces state to FETCH.
- `op`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU result == 0.
- `immSrc`  out  2  immediate format select: 00 I, 01 S, 10 B, 11 J.
- `ALUSrcA`  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 data.
- `ALUSrcB`  out  2  ALU B select: 00 rs2 data, 01 ImmExt, 10 constant 4.
- `ResultSrc`  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult.
- `AdrSrc`  out  1  memory address select: 0 PC, 1 Result.
- `ALUControl`  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `IRWrite`  out  1  load the instruction register and OldPC.
- `PCWrite`  out  1  load PC.
- `RegWrite`  out  1  register file write enable.
- `MemWrite`  out  1  memory write enable.
- `stateDbg`  out  4  current state encoding, for the bench only.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 are unreachable; if one is ever entered, the next state is FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE branches on `op`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - Any other opcode → FETCH (instruction skipped, no writes).
  - MEMADR→MEMREAD if op[5]=0, otherwise MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER and EXECUTEI → ALUWB→FETCH.
  - BEQ→FETCH.
  - JAL→ALUWB.
- Per-state outputs (Moore). Any output not listed for a state is 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- `PCWrite` = PCUpdate | (Branch & zero).
- `immSrc` is combinational from `op`, independent of state:
  - lw or I-ALU → 00.
  - sw → 01.
  - beq → 10.
  - jal → 11.
  - Any other opcode → 00.
- ALU decode (ALUOp is internal):
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10, by `funct3`:
    - 000 → sub if (op[5] & funct7b5), otherwise add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - Other values → add.
  - ALUOp 11 → add.
- No output is ever X.

## Timing
- `reset` high at a rising edge → state=FETCH from the next cycle. Outputs then equal the FETCH values: IRWrite=1, PCWrite=1, RegWrite=0, MemWrite=0, stateDbg=0.
- Reset mid-instruction (any state) aborts the instruction. No write enable is asserted in the cycle after the reset edge except the FETCH enables.
- Cycles per instruction, FETCH to the next FETCH:
  - lw 5.
  - sw 4.
  - R-type 4.
  - I-ALU 4.
  - beq 3.
  - jal 4.
  - Illegal opcode 2.
- `zero` is sampled combinationally only in BEQ. `PCWrite` may toggle within BEQ if `zero` changes.
- RegWrite, MemWrite and IRWrite are each high for exactly one cycle per qualifying instruction.

## Structure
- Package `riscv_pkg` holds:
  - `state_t` enum with the encodings above.
  - Opcode localparams: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL.
  - ALUOp and ALUControl constants.
  - immSrc format constants, shared with the immediate extender.
- Sub-module `aludec` (combinational): ALUOp, funct3, op[5], funct7b5 → ALUControl.
- The FSM next-state logic, output logic and immSrc decode stay in `multicycle_ctrl`.

## Test plan
- Reset then lw (op=0000011): stateDbg must be 0,1,2,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01. immSrc=00.
- sw (op=0100011): states 0,1,2,5,0. MemWrite=1 only in state 5 with AdrSrc=1. immSrc=01.
- beq with zero=1 and then zero=0: PCWrite=1 in state 9 only when zero=1. ALUControl=001 in state 9. immSrc=10.
- R-type with funct3=000, funct7b5=1: ALUControl=001 in EXECUTER. With funct3=111: ALUControl=010. With funct3=010: ALUControl=101.
- jal (op=1101111): states 0,1,10,8,0. PCWrite=1 in state 10 with ALUSrcA=01, ALUSrcB=10. immSrc=11.
- Illegal op=1111111: states 0,1,0 with no writes. Reset asserted in MEMREAD: state is 0 in the next cycle and RegWrite never pulses.
